// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: default geometry and zero-register address shared by the register file
package regfile_sb_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_AW = 5;
  localparam int ZERO_ADDR = 0;
endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, write and reserve ports of the scoreboarded register file
interface regfile_sb_if
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW = DEF_AW
) ();
  logic [AW-1:0] ra1, ra2, wa, rsv_a;
  logic [WIDTH-1:0] rd1, rd2, wd;
  logic busy1, busy2, we, rsv;
  logic [AW:0] busy_cnt;
  modport master (
    output ra1, ra2, we, wa, wd, rsv, rsv_a,
    input rd1, rd2, busy1, busy2, busy_cnt
  );
  modport slave (
    input ra1, ra2, we, wa, wd, rsv, rsv_a,
    output rd1, rd2, busy1, busy2, busy_cnt
  );
endinterface

// File: rtl/regfile_word.sv
// regfile_word: one register with load enable and synchronous active-high clear
module regfile_word #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with busy scoreboard; define REGFILE_BYPASS_EN for same-cycle write forwarding
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW = DEF_AW
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  localparam logic [AW-1:0] Z = AW'(ZERO_ADDR);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0] busy, busy_nx;
  logic [AW:0] cnt, cnt_nx;
  logic wr, rs, s, c, fwd1, fwd2;
  assign regs[0] = '0;
  for (genvar i = 1; i < DEPTH; i++) begin : g_word
    regfile_word #(.WIDTH(WIDTH)) u_word (
      .clk(clk),
      .clr(rst),
      .en (wr && bus.wa == AW'(i)),
      .d  (bus.wd),
      .q  (regs[i])
    );
  end
  always_comb begin
    wr = bus.we && bus.wa != Z;
    rs = bus.rsv && bus.rsv_a != Z;
    busy_nx = '0;
    for (int k = 1; k < DEPTH; k++)
      busy_nx[k] = (rs && bus.rsv_a == AW'(k)) || (busy[k] && !(wr && bus.wa == AW'(k)));
    s = rs && !busy[bus.rsv_a];
    c = wr && busy[bus.wa] && !(rs && bus.rsv_a == bus.wa);
    cnt_nx = cnt + (AW+1)'(s) - (AW+1)'(c);
  end
  always_ff @(posedge clk)
    if (rst) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nx;
      cnt  <= cnt_nx;
    end
  always_comb begin
`ifdef REGFILE_BYPASS_EN
    fwd1 = wr && bus.wa == bus.ra1;
    fwd2 = wr && bus.wa == bus.ra2;
`else
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
    bus.rd1 = fwd1 ? bus.wd : regs[bus.ra1];
    bus.rd2 = fwd2 ? bus.wd : regs[bus.ra2];
    bus.busy1 = fwd1 ? busy_nx[bus.ra1] : busy[bus.ra1];
    bus.busy2 = fwd2 ? busy_nx[bus.ra2] : busy[bus.ra2];
  end
  assign bus.busy_cnt = cnt;
endmodule
